// File: rtl/button_gesture.sv
// rtl/button_gesture.sv - classifies debounced button activity into short/long/double/repeat gestures
module button_gesture #(
    parameter int LONG_TICKS   = 160,
    parameter int DBL_TICKS    = 60,
    parameter int REPEAT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_db,
    input  logic       btn_rise,
    input  logic       btn_fall,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       repeat_pulse,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS1   = 3'd1,
        S_WAIT2    = 3'd2,
        S_HELD     = 3'd3,
        S_WAIT_REL = 3'd4
    } state_t;

    localparam logic [15:0] LONG_LAST   = 16'(LONG_TICKS - 1);
    localparam logic [15:0] DBL_LAST    = 16'(DBL_TICKS - 1);
    localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS - 1);

    state_t      cur_state;
    state_t      nxt_state;
    logic [15:0] cnt;
    logic        short_nxt;
    logic        long_nxt;
    logic        dbl_nxt;
    logic        rep_nxt;
    logic        counting;

    assign counting = (cur_state == S_PRESS1) || (cur_state == S_WAIT2) || (cur_state == S_HELD);

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= S_IDLE;
            cnt          <= 16'd0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= dbl_nxt;
            repeat_pulse <= rep_nxt;
            busy         <= (nxt_state != S_IDLE);
            if ((nxt_state != cur_state) || rep_nxt) begin
                cnt <= 16'd0;
            end else if (tick && counting) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Releases always take priority over the terminal tick in the same cycle
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (btn_rise) nxt_state = S_PRESS1;
            end
            S_PRESS1: begin
                if (btn_fall)                        nxt_state = S_WAIT2;
                else if (tick && (cnt == LONG_LAST)) nxt_state = S_HELD;
            end
            S_WAIT2: begin
                if (btn_rise)                       nxt_state = S_WAIT_REL;
                else if (tick && (cnt == DBL_LAST)) nxt_state = S_IDLE;
            end
            S_HELD: begin
                if (btn_fall || !btn_db) nxt_state = S_IDLE;
            end
            S_WAIT_REL: begin
                if (btn_fall || !btn_db) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        dbl_nxt   = 1'b0;
        rep_nxt   = 1'b0;
        case (cur_state)
            S_PRESS1: long_nxt  = (nxt_state == S_HELD);
            S_WAIT2: begin
                dbl_nxt   = (nxt_state == S_WAIT_REL);
                short_nxt = (nxt_state == S_IDLE);
            end
            S_HELD:   rep_nxt   = (nxt_state == S_HELD) && tick && (cnt == REPEAT_LAST);
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_button_gesture.sv
// tb/tb_button_gesture.sv - randomized and directed self-checking bench for button_gesture
module tb_button_gesture;

    localparam int LONG = 8;
    localparam int DBL  = 4;
    localparam int REP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_db = 1'b0;
    logic       btn_rise = 1'b0;
    logic       btn_fall = 1'b0;
    logic       short_press, long_press, double_click, repeat_pulse, busy;
    logic [2:0] state;
    logic [7:0] obs;

    int compared = 0;
    int mism = 0;

    // Reference model: gesture phase plus ticks elapsed within that phase
    int         m_ph = 0;
    int         m_el = 0;
    logic [7:0] exp_v = 8'h00;

    button_gesture #(.LONG_TICKS(LONG), .DBL_TICKS(DBL), .REPEAT_TICKS(REP)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_db(btn_db), .btn_rise(btn_rise),
        .btn_fall(btn_fall), .short_press(short_press), .long_press(long_press),
        .double_click(double_click), .repeat_pulse(repeat_pulse), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, busy, short_press, long_press, double_click, repeat_pulse};

    task automatic step(input logic r, input logic t, input logic d, input logic ri, input logic fa);
        logic ps, pl, pd, pr;
        rst = r; tick = t; btn_db = d; btn_rise = ri; btn_fall = fa;
        @(posedge clk);
        ps = 0; pl = 0; pd = 0; pr = 0;
        if (r) begin
            m_ph = 0; m_el = 0;
        end else begin
            case (m_ph)
                0: if (ri) begin m_ph = 1; m_el = 0; end
                1: if (fa) begin m_ph = 2; m_el = 0; end
                   else if (t) begin
                       if (m_el + 1 == LONG) begin m_ph = 3; m_el = 0; pl = 1; end
                       else m_el++;
                   end
                2: if (ri) begin m_ph = 4; m_el = 0; pd = 1; end
                   else if (t) begin
                       if (m_el + 1 == DBL) begin m_ph = 0; m_el = 0; ps = 1; end
                       else m_el++;
                   end
                3: if (fa || !d) begin m_ph = 0; m_el = 0; end
                   else if (t) begin
                       if (m_el + 1 == REP) begin m_el = 0; pr = 1; end
                       else m_el++;
                   end
                default: if (fa || !d) begin m_ph = 0; m_el = 0; end
            endcase
        end
        exp_v = {3'(m_ph), (m_ph != 0), ps, pl, pd, pr};
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 1, i[0]);
            compared++;
            if (obs !== 8'h00) begin
                mism++;
                $display("FAIL reset cyc%0d obs=%b exp=%b", i, obs, 8'h00);
            end
        end
    endtask

    task automatic test_short();
        int fall_at = 3;
        int hit = -1;
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, (i < fall_at), (i == 0), (i == fall_at));
            compared++;
            if (obs !== exp_v) begin
                mism++;
                $display("FAIL short cyc%0d obs=%b exp=%b", i, obs, exp_v);
            end
            if (short_press) begin hit = i; n++; end
        end
        compared++;
        if (hit !== fall_at + DBL || n !== 1) begin
            mism++;
            $display("FAIL short_timing at=%0d count=%0d exp at=%0d count=1", hit, n, fall_at + DBL);
        end
        compared++;
        if ({state, busy} !== 4'b0000) begin
            mism++;
            $display("FAIL short_idle obs=%b exp=0000", {state, busy});
        end
    endtask

    task automatic test_double();
        int ns = 0;
        logic d;
        for (int i = 0; i < 8; i++) begin
            d = (i < 2) || (i >= 4 && i < 6);
            step(0, 1, d, (i == 0 || i == 4), (i == 2 || i == 6));
            compared++;
            if (obs !== exp_v) begin
                mism++;
                $display("FAIL double cyc%0d obs=%b exp=%b", i, obs, exp_v);
            end
            if (short_press) ns++;
            if (i == 4) begin
                compared++;
                if (double_click !== 1'b1 || state !== 3'd4) begin
                    mism++;
                    $display("FAIL double_pulse dbl=%b state=%0d exp dbl=1 state=4", double_click, state);
                end
            end
        end
        compared++;
        if (state !== 3'd0 || ns !== 0) begin
            mism++;
            $display("FAIL double_end state=%0d shorts=%0d exp state=0 shorts=0", state, ns);
        end
    endtask

    task automatic test_long_repeat();
        int nl = 0, nr = 0, late = 0;
        for (int i = 0; i < 28; i++) begin
            step(0, 1, (i <= 20), (i == 0), (i == 21));
            compared++;
            if (obs !== exp_v) begin
                mism++;
                $display("FAIL long cyc%0d obs=%b exp=%b", i, obs, exp_v);
            end
            if (long_press) begin
                nl++;
                compared++;
                if (i !== LONG) begin
                    mism++;
                    $display("FAIL long_timing at=%0d exp=%0d", i, LONG);
                end
            end
            if (repeat_pulse) nr++;
            if (i >= 21 && (obs[3:0] != 4'b0)) late++;
        end
        compared++;
        if (nl !== 1 || nr !== 4 || late !== 0) begin
            mism++;
            $display("FAIL long_counts long=%0d rep=%0d late=%0d exp 1/4/0", nl, nr, late);
        end
    endtask

    task automatic test_collisions();
        for (int i = 0; i < 15; i++) begin
            step(0, 1, (i < 8) || (i >= 12 && i < 14), (i == 0 || i == 12), (i == 8 || i == 14));
            compared++;
            if (obs !== exp_v) begin
                mism++;
                $display("FAIL collide cyc%0d obs=%b exp=%b", i, obs, exp_v);
            end
            if (i == 8) begin
                compared++;
                if (state !== 3'd2 || long_press !== 1'b0) begin
                    mism++;
                    $display("FAIL collide_long state=%0d long=%b exp state=2 long=0", state, long_press);
                end
            end
            if (i == 12) begin
                compared++;
                if (double_click !== 1'b1 || short_press !== 1'b0) begin
                    mism++;
                    $display("FAIL collide_dbl dbl=%b short=%b exp dbl=1 short=0", double_click, short_press);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) begin
            if (i < 10)       step(0, 1, 1, (i == 0), 0);
            else if (i < 14)  step(1, 0, 1, i[0], ~i[0]);
            else if (i < 29)  step(0, (i >= 16), 1, 0, 0);
            else              step(0, 1, 1, 1, 0);
            compared++;
            if (obs !== exp_v) begin
                mism++;
                $display("FAIL rstmid cyc%0d obs=%b exp=%b", i, obs, exp_v);
            end
            if (i >= 10 && i < 29) begin
                compared++;
                if (obs !== 8'h00) begin
                    mism++;
                    $display("FAIL rstmid_idle cyc%0d obs=%b exp=00000000", i, obs);
                end
            end
        end
        compared++;
        if (state !== 3'd1) begin
            mism++;
            $display("FAIL rstmid_restart state=%0d exp=1", state);
        end
        step(0, 1, 0, 0, 1);
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        logic r, t, ri, fa;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            t  = ($urandom_range(0, 2) != 0);
            ri = 1'b0;
            fa = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                lvl = ~lvl;
                ri = lvl;
                fa = ~lvl;
            end else if ($urandom_range(0, 49) == 0) begin
                ri = $urandom_range(0, 1);
                fa = ~ri;
            end
            step(r, t, lvl, ri, fa);
            compared++;
            if (obs !== exp_v || !$onehot0(obs[3:0])) begin
                mism++;
                $display("FAIL random cyc%0d obs=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
